// File: rtl/quad_if.sv
// quad_if: quadrature decoder signal bundle; master drives a, b, en, clr and observes step, dir, err, err_sticky (and err_cnt when QDEC_ERR_CNT_EN is defined)
interface quad_if;
  logic a, b, en, clr, step, dir, err, err_sticky;
`ifdef QDEC_ERR_CNT_EN
  logic [3:0] err_cnt;
  modport master (output a, b, en, clr, input step, dir, err, err_sticky, err_cnt);
  modport slave (input a, b, en, clr, output step, dir, err, err_sticky, err_cnt);
`else
  modport master (output a, b, en, clr, input step, dir, err, err_sticky);
  modport slave (input a, b, en, clr, output step, dir, err, err_sticky);
`endif
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: synchronized, glitch-filtered quadrature decoder with step/dir pulses and error status; clk, rst (async, active-high), q (quad_if.slave: a, b, en, clr in; step, dir, err, err_sticky out; err_cnt out when QDEC_ERR_CNT_EN is defined)
module quad_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN = 3
) (
  input logic clk,
  input logic rst,
  quad_if.slave q
);
  typedef enum logic {INIT, RUN} state_t;
  localparam logic [4:0] INIT_LAST = 5'(SYNC_STAGES + FILT_LEN - 1);
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);
  state_t state;
  logic [SYNC_STAGES-1:0] sync_a, sync_b;
  logic [1:0] smp, filt, prev, diff;
  logic [3:0] cnt_a, cnt_b;
  logic [4:0] init_cnt;
  logic hit_a, hit_b, up, err_now;
  function automatic logic [1:0] idx(input logic [1:0] v);
    return {v[1], v[1] ^ v[0]};
  endfunction
  always_comb begin
    smp = {sync_a[SYNC_STAGES-1], sync_b[SYNC_STAGES-1]};
    hit_a = (smp[1] != filt[1]) && (cnt_a == FILT_LAST);
    hit_b = (smp[0] != filt[0]) && (cnt_b == FILT_LAST);
    diff = filt ^ prev;
    up = idx(filt) == idx(prev) + 2'd1;
    err_now = (state == RUN) && q.en && (&diff);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      sync_a <= '0;
      sync_b <= '0;
      filt <= '0;
      prev <= '0;
      cnt_a <= '0;
      cnt_b <= '0;
      init_cnt <= '0;
      q.step <= 1'b0;
      q.dir <= 1'b1;
      q.err <= 1'b0;
      q.err_sticky <= 1'b0;
`ifdef QDEC_ERR_CNT_EN
      q.err_cnt <= '0;
`endif
    end else begin
      sync_a <= {sync_a[SYNC_STAGES-2:0], q.a};
      sync_b <= {sync_b[SYNC_STAGES-2:0], q.b};
      q.err <= err_now;
      q.err_sticky <= err_now | (q.err_sticky & ~q.clr);
`ifdef QDEC_ERR_CNT_EN
      q.err_cnt <= err_now ? (q.clr ? 4'd1 : q.err_cnt + {3'd0, q.err_cnt != 4'd15}) : (q.clr ? 4'd0 : q.err_cnt);
`endif
      if (state == INIT) begin
        q.step <= 1'b0;
        init_cnt <= init_cnt + 5'd1;
        if (init_cnt == INIT_LAST) begin
          state <= RUN;
          filt <= smp;
          prev <= smp;
        end
      end else begin
        q.step <= q.en && (^diff);
        if (q.en && (^diff)) q.dir <= up;
        prev <= filt;
        filt <= filt ^ {hit_a, hit_b};
        cnt_a <= ((smp[1] == filt[1]) || hit_a) ? 4'd0 : cnt_a + 4'd1;
        cnt_b <= ((smp[0] == filt[0]) || hit_b) ? 4'd0 : cnt_b + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: table-driven, directed and randomized checks of quad_decoder against a history-based reference model
module tb_quad_decoder;
  localparam int S = 2;
  localparam int F = 3;
  localparam int HN = 16384;
  typedef struct {
    logic [1:0] ab;
    int hold;
    logic en;
    logic clr;
    int steps;
    int errs;
    logic dir;
    logic sticky;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  quad_if qi();
  quad_decoder #(.SYNC_STAGES(S), .FILT_LEN(F)) dut (.clk(clk), .rst(rst), .q(qi));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, nstep = 0, nerr = 0;
  logic [1:0] hist [0:HN-1];
  int n = 0, last_a = 0, last_b = 0;
  logic [1:0] mf = 2'b00, mp = 2'b00;
  logic m_step = 1'b0, m_dir = 1'b1, m_err = 1'b0, m_sticky = 1'b0;
  logic [3:0] m_cnt = 4'd0;
  // raw input captured at edge e-S is what the filter sees at edge e
  function automatic logic [1:0] samp(input int e);
    return (e > S) ? hist[(e - S) % HN] : 2'b00;
  endfunction
  function automatic int pos(input logic [1:0] v);
    return v == 2'b00 ? 0 : v == 2'b01 ? 1 : v == 2'b11 ? 2 : 3;
  endfunction
  // a channel flips when its last F samples, all newer than its previous flip, disagree with it
  function automatic logic flips(input int ch, input int last);
    logic [1:0] s;
    if (n - F + 1 <= last) return 1'b0;
    for (int j = 0; j < F; j++) begin
      s = samp(n - j);
      if (s[ch] == mf[ch]) return 1'b0;
    end
    return 1'b1;
  endfunction
  task automatic tick();
    logic [1:0] d;
    if (rst) begin
      n = 0; mf = 2'b00; mp = 2'b00; m_step = 1'b0; m_dir = 1'b1; m_err = 1'b0; m_sticky = 1'b0; m_cnt = 4'd0;
    end else begin
      n++;
      hist[n % HN] = {qi.a, qi.b};
      d = mf ^ mp;
      m_step = (n > S + F) && qi.en && (d == 2'b01 || d == 2'b10);
      m_err = (n > S + F) && qi.en && (d == 2'b11);
      if (m_step) m_dir = ((pos(mf) - pos(mp) + 4) % 4) == 1;
      if (n == S + F) begin
        mf = samp(n); mp = mf; last_a = n; last_b = n;
      end else if (n > S + F) begin
        mp = mf;
        if (flips(1, last_a)) begin mf[1] = ~mf[1]; last_a = n; end
        if (flips(0, last_b)) begin mf[0] = ~mf[0]; last_b = n; end
      end
      m_sticky = m_err || (m_sticky && !qi.clr);
      m_cnt = m_err ? (qi.clr ? 4'd1 : (m_cnt == 4'd15 ? 4'd15 : m_cnt + 4'd1)) : (qi.clr ? 4'd0 : m_cnt);
    end
  endtask
  always @(posedge clk or posedge rst) tick();
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    chk("step", int'(qi.step), int'(m_step));
    chk("dir", int'(qi.dir), int'(m_dir));
    chk("err", int'(qi.err), int'(m_err));
    chk("err_sticky", int'(qi.err_sticky), int'(m_sticky));
`ifdef QDEC_ERR_CNT_EN
    chk("err_cnt", int'(qi.err_cnt), int'(m_cnt));
`endif
    nstep += int'(qi.step);
    nerr += int'(qi.err);
  endtask
  task automatic apply_ab(input logic [1:0] ab, input int cycles);
    {qi.a, qi.b} = ab;
    repeat (cycles) cyc();
  endtask
  task automatic do_reset(input logic [1:0] ab, input int settle);
    rst = 1'b1;
    {qi.a, qi.b} = ab;
    qi.en = 1'b1;
    qi.clr = 1'b0;
    cyc();
    chk("rst_step", int'(qi.step), 0);
    chk("rst_dir", int'(qi.dir), 1);
    chk("rst_err", int'(qi.err), 0);
    chk("rst_sticky", int'(qi.err_sticky), 0);
`ifdef QDEC_ERR_CNT_EN
    chk("rst_err_cnt", int'(qi.err_cnt), 0);
`endif
    cyc();
    rst = 1'b0;
    nstep = 0;
    nerr = 0;
    repeat (settle) cyc();
  endtask
  initial begin
    vec_t tbl [15];
    int lat;
    tbl = '{
      '{2'b01, 8, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0},
      '{2'b11, 8, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0},
      '{2'b10, 8, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0},
      '{2'b00, 8, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0},
      '{2'b10, 8, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0},
      '{2'b00, 8, 1'b1, 1'b0, 1, 0, 1'b1, 1'b0},
      '{2'b10, 2, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b00, 8, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b11, 8, 1'b1, 1'b0, 0, 1, 1'b1, 1'b1},
      '{2'b11, 2, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0},
      '{2'b01, 8, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b00, 8, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b10, 8, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b10, 10, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0},
      '{2'b11, 8, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0}
    };
    qi.a = 1'b0; qi.b = 1'b0; qi.en = 1'b1; qi.clr = 1'b0;
    do_reset(2'b11, 10);
    chk("init11_steps", nstep, 0);
    chk("init11_errs", nerr, 0);
    apply_ab(2'b10, 8);
    chk("run_after_init_steps", nstep, 1);
    chk("run_after_init_dir", int'(qi.dir), 1);
    do_reset(2'b00, 10);
    for (int i = 0; i < 15; i++) begin
      qi.en = tbl[i].en;
      qi.clr = tbl[i].clr;
      nstep = 0;
      nerr = 0;
      apply_ab(tbl[i].ab, tbl[i].hold);
      chk($sformatf("row%0d_steps", i), nstep, tbl[i].steps);
      chk($sformatf("row%0d_errs", i), nerr, tbl[i].errs);
      chk($sformatf("row%0d_dir", i), int'(qi.dir), int'(tbl[i].dir));
      chk($sformatf("row%0d_sticky", i), int'(qi.err_sticky), int'(tbl[i].sticky));
    end
    qi.en = 1'b1;
    qi.clr = 1'b0;
    do_reset(2'b00, 10);
    lat = 0;
    {qi.a, qi.b} = 2'b01;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (qi.step && lat == 0) lat = k;
    end
    chk("latency_negedges", lat, 6);
    do_reset(2'b00, 10);
    for (int i = 0; i < 17; i++) apply_ab((i % 2 == 0) ? 2'b11 : 2'b00, 8);
    chk("illegal17_errs", nerr, 17);
    chk("illegal17_steps", nstep, 0);
    chk("illegal17_sticky", int'(qi.err_sticky), 1);
`ifdef QDEC_ERR_CNT_EN
    chk("illegal17_err_cnt", int'(qi.err_cnt), 15);
`endif
    {qi.a, qi.b} = 2'b00;
    repeat (5) cyc();
    qi.clr = 1'b1;
    cyc();
    qi.clr = 1'b0;
    chk("clr_vs_err_err", int'(qi.err), 1);
    chk("clr_vs_err_sticky", int'(qi.err_sticky), 1);
`ifdef QDEC_ERR_CNT_EN
    chk("clr_vs_err_cnt", int'(qi.err_cnt), 1);
`endif
    cyc();
    qi.clr = 1'b1;
    cyc();
    qi.clr = 1'b0;
    chk("clr_sticky", int'(qi.err_sticky), 0);
`ifdef QDEC_ERR_CNT_EN
    chk("clr_err_cnt", int'(qi.err_cnt), 0);
`endif
    do_reset(2'b00, 10);
    for (int i = 0; i < 1500; i++) begin
      qi.en = $urandom_range(0, 7) != 0;
      qi.clr = $urandom_range(0, 15) == 0;
      {qi.a, qi.b} = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 6)) begin
        cyc();
        qi.clr = 1'b0;
        if ($urandom_range(0, 299) == 0) begin
          rst = 1'b1;
          cyc();
          rst = 1'b0;
        end
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per input, legal range 2..4.
REQ-002 SHALL have parameter FILT_LEN, default 3: consecutive-cycle agreement needed to accept a new level, legal range 1..15.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port a  input  1  quadrature channel A, asynchronous to clk.
REQ-006 SHALL have port b  input  1  quadrature channel B, asynchronous to clk.
REQ-007 SHALL have port en  input  1  decode enable; low suppresses step and err.
REQ-008 SHALL have port clr  input  1  synchronous clear of error status.
REQ-009 SHALL have port step  output  1  one-cycle pulse per accepted valid quadrature transition; drives a counter's enable.
REQ-010 SHALL have port dir  output  1  direction of the most recent step: 1 = up, 0 = down; drives a counter's up_down.
REQ-011 SHALL have port err  output  1  one-cycle pulse on an illegal transition.
REQ-012 SHALL have port err_sticky  output  1  set by any err pulse; held until clr or rst.

Function
REQ-013 SHALL pass each of a and b through its own SYNC_STAGES-flop synchronizer.
REQ-014 SHALL filter each synchronized channel independently: the filtered level updates on the edge at which the synchronized sample has differed from it for FILT_LEN consecutive samples; any agreeing sample resets that channel's mismatch count to 0.
REQ-015 SHALL implement FSM states INIT and RUN; rst forces INIT.
REQ-016 In INIT the block SHALL count SYNC_STAGES+FILT_LEN cycles, then load the synchronized samples directly into the filtered and previous-state registers, enter RUN, and emit no step and no err.
REQ-017 In RUN, state {A,B} SHALL follow the up sequence 00->01->11->10->00; the reverse order is down.
REQ-018 A single-bit change in filtered {A,B} SHALL produce step=1 for exactly one cycle, with dir updated in the same cycle.
REQ-019 A two-bit change (both filters updating on the same edge) SHALL produce err=1 for one cycle, no step, and dir unchanged.
REQ-020 Latency SHALL be SYNC_STAGES+FILT_LEN edges from the edge first capturing a new stable level to the edge asserting step, which is 5 at defaults.
REQ-021 With en=0 the block SHALL keep step=0 and err=0 but continue synchronizing, filtering and updating the previous state, so raising en causes no spurious pulse.
REQ-022 err_sticky SHALL set on the edge asserting err; when clr=1 it SHALL clear; an err on the same edge as clr SHALL win (err_sticky=1).
REQ-023 A direction reversal (e.g., 01->00 after 00->01) SHALL be a valid step with the new dir and SHALL NOT be an error.
REQ-024 Pulses narrower than FILT_LEN cycles after synchronization SHALL produce neither step nor err.

Reset
REQ-025 On rst, the block SHALL clear all synchronizer, filter, mismatch-count and previous-state registers to 0 and enter FSM state INIT.
REQ-026 On rst, outputs SHALL be step=0, dir=1, err=0 and err_sticky=0; under QDEC_ERR_CNT_EN, err_cnt=0.
REQ-027 Reset asserted mid-transition SHALL abandon any partial filter count; after release the block SHALL re-run INIT.

Configuration
REQ-028 With macro QDEC_ERR_CNT_EN defined, the block SHALL add port err_cnt (output, 4 bits): a count of err pulses that saturates at 15 and is cleared by clr or rst, with err winning over clr on the same edge (result 1).
REQ-029 Without QDEC_ERR_CNT_EN, port err_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset release with a=1, b=1 held for 10 cycles -> RUN is entered; step and err stay 0 throughout.
REQ-031 After INIT at 00, drive a/b through 01,11,10,00 with each state held 8 cycles -> 4 step pulses, dir=1, each step 5 edges after the capture edge.
REQ-032 From 00, drive 10 and then 00 -> first step has dir=0; reversal step has dir=1; err stays 0.
REQ-033 From 00, a 2-cycle glitch on a -> no step, no err; then switching a and b together 00->11 -> err pulse, err_sticky=1, dir unchanged; clr=1 for one cycle -> err_sticky=0.
REQ-034 en=0 during 3 valid transitions, then en=1 with no further input change -> no step pulses at any point.
REQ-035 With QDEC_ERR_CNT_EN, 17 illegal transitions -> err_cnt=15; clr and err on the same edge -> err_cnt=1.
